// File: rtl/decode_stage_if.sv
// Fetch-to-decode-to-execute pipeline bundle for the RV32I decode stage.
// master drives fetch data and downstream control; slave is the decode stage.
interface decode_stage_if;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_ce;
  logic        i_stall;
  logic        i_flush;
  logic [4:0]  o_rs1_addr_comb;
  logic [4:0]  o_rs2_addr_comb;
  logic [31:0] o_pc;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_imm;
  logic [2:0]  o_funct3;
  logic [3:0]  o_alu_op;
  logic [10:0] o_opcode;
  logic [3:0]  o_exception;
  logic        o_ce;
  logic        o_stall;
  logic        o_flush;

  modport master (
    output i_pc, i_instr, i_ce, i_stall, i_flush,
    input  o_rs1_addr_comb, o_rs2_addr_comb, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr,
           o_imm, o_funct3, o_alu_op, o_opcode, o_exception, o_ce, o_stall, o_flush
  );

  modport slave (
    input  i_pc, i_instr, i_ce, i_stall, i_flush,
    output o_rs1_addr_comb, o_rs2_addr_comb, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr,
           o_imm, o_funct3, o_alu_op, o_opcode, o_exception, o_ce, o_stall, o_flush
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers register addresses, immediate, ALU op, one-hot
// opcode class and exception flags for execute; regfile read addresses are combinational.
module decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input logic             clk,
  input logic             rstn,
  decode_stage_if.slave   io_bus
);

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSlt  = 4'd2;
  localparam logic [3:0] AluSltu = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluOr   = 4'd5;
  localparam logic [3:0] AluAnd  = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;
  localparam logic [3:0] AluEq   = 4'd10;
  localparam logic [3:0] AluNeq  = 4'd11;
  localparam logic [3:0] AluGe   = 4'd12;
  localparam logic [3:0] AluGeu  = 4'd13;
  localparam logic [3:0] AluLt   = 4'd14;
  localparam logic [3:0] AluLtu  = 4'd15;

  // sub_en distinguishes R-type (SUB allowed) from I-type (funct7 bits are immediate).
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic sub_en);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_en) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [31:0] w_instr;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_stall;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  logic [31:0] w_imm;
  logic [3:0]  w_alu;
  logic [10:0] w_cls;
  logic [4:0]  w_rd;
  logic        w_ill, w_ecall, w_ebreak, w_mret;

  logic [31:0] r_pc;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [31:0] r_imm;
  logic [2:0]  r_f3;
  logic [3:0]  r_alu;
  logic [10:0] r_opc;
  logic [3:0]  r_exc;
  logic        r_ce;

  assign w_instr = io_bus.i_instr;
  assign w_op    = w_instr[6:0];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];
  assign w_stall = io_bus.i_stall;

  assign io_bus.o_rs1_addr_comb = w_instr[19:15];
  assign io_bus.o_rs2_addr_comb = w_instr[24:20];
  assign io_bus.o_stall         = w_stall;
  assign io_bus.o_flush         = io_bus.i_flush;

  assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                     w_instr[11:8], 1'b0};
  assign w_imm_u  = {w_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                     w_instr[30:21], 1'b0};
  assign w_imm_sh = {27'b0, w_instr[24:20]};

  always_comb begin
    w_imm    = '0;
    w_alu    = AluAdd;
    w_cls    = '0;
    w_rd     = w_instr[11:7];
    w_ill    = 1'b0;
    w_ecall  = 1'b0;
    w_ebreak = 1'b0;
    w_mret   = 1'b0;
    case (w_op)
      OpRtype: begin
        w_cls[0] = 1'b1;
        w_ill    = !((w_f7 == 7'h00) ||
                     ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
        w_alu    = arith_op(w_f3, w_f7[5], 1'b1);
      end
      OpItype: begin
        w_cls[1] = 1'b1;
        w_alu    = arith_op(w_f3, w_f7[5], 1'b0);
        if (w_f3 == 3'b001) begin
          w_imm = w_imm_sh;
          w_ill = (w_f7 != 7'h00);
        end else if (w_f3 == 3'b101) begin
          w_imm = w_imm_sh;
          w_ill = !((w_f7 == 7'h00) || (w_f7 == 7'h20));
        end else begin
          w_imm = w_imm_i;
        end
      end
      OpLoad: begin
        w_cls[2] = 1'b1;
        w_imm    = w_imm_i;
        w_ill    = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OpStore: begin
        w_cls[3] = 1'b1;
        w_imm    = w_imm_s;
        w_rd     = '0;
        w_ill    = (w_f3 > 3'b010);
      end
      OpBranch: begin
        w_cls[4] = 1'b1;
        w_imm    = w_imm_b;
        w_rd     = '0;
        case (w_f3)
          3'b000:  w_alu = AluEq;
          3'b001:  w_alu = AluNeq;
          3'b100:  w_alu = AluLt;
          3'b101:  w_alu = AluGe;
          3'b110:  w_alu = AluLtu;
          3'b111:  w_alu = AluGeu;
          default: w_ill = 1'b1;
        endcase
      end
      OpJal: begin
        w_cls[5] = 1'b1;
        w_imm    = w_imm_j;
      end
      OpJalr: begin
        w_cls[6] = 1'b1;
        w_imm    = w_imm_i;
        w_ill    = (w_f3 != 3'b000);
      end
      OpLui: begin
        w_cls[7] = 1'b1;
        w_imm    = w_imm_u;
      end
      OpAuipc: begin
        w_cls[8] = 1'b1;
        w_imm    = w_imm_u;
      end
      OpSystem: begin
        w_cls[9] = 1'b1;
        w_imm    = w_imm_i;
        // funct3 != 0 is a CSR access: legal, no trap.
        if (w_f3 == 3'b000) begin
          w_rd = '0;
          case (w_instr)
            32'h0000_0073: w_ecall  = 1'b1;
            32'h0010_0073: w_ebreak = 1'b1;
            32'h3020_0073: w_mret   = 1'b1;
            default:       w_ill    = 1'b1;
          endcase
        end
      end
      OpFence: begin
        w_cls[10] = 1'b1;
        w_rd      = '0;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_cls = '0;
      w_rd  = '0;
      w_alu = AluAdd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc  <= PC_RESET;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
      r_imm <= '0;
      r_f3  <= '0;
      r_alu <= '0;
      r_opc <= '0;
      r_exc <= '0;
      r_ce  <= 1'b0;
    end else begin
      // Stall beats flush: o_ce and the decoded fields both hold.
      if (!w_stall) begin
        r_ce <= io_bus.i_flush ? 1'b0 : io_bus.i_ce;
      end
      if (io_bus.i_ce && !w_stall) begin
        r_pc  <= io_bus.i_pc;
        r_rs1 <= w_instr[19:15];
        r_rs2 <= w_instr[24:20];
        r_rd  <= w_rd;
        r_imm <= w_imm;
        r_f3  <= w_f3;
        r_alu <= w_alu;
        r_opc <= w_cls;
        r_exc <= {w_mret, w_ebreak, w_ecall, w_ill};
      end
    end
  end

  assign io_bus.o_pc        = r_pc;
  assign io_bus.o_rs1_addr  = r_rs1;
  assign io_bus.o_rs2_addr  = r_rs2;
  assign io_bus.o_rd_addr   = r_rd;
  assign io_bus.o_imm       = r_imm;
  assign io_bus.o_funct3    = r_f3;
  assign io_bus.o_alu_op    = r_alu;
  assign io_bus.o_opcode    = r_opc;
  assign io_bus.o_exception = r_exc;
  assign io_bus.o_ce        = r_ce;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plus random instructions, each accepted edge
// pushes its expected result; a monitor pops and compares after every clock edge.
module tb_decode_stage;

  localparam logic [31:0] PcReset = 32'h0000_0080;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [10:0] opc;
    logic [3:0]  exc;
    bit          chk_imm;
  } exp_t;

  typedef struct {
    bit   ce;
    bit   upd;
    exp_t d;
  } item_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage #(
    .PC_RESET(PcReset)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .io_bus(bus)
  );

  item_t sbq[$];
  int    n_checks = 0;
  int    n_fail = 0;

  logic [3:0] arith_tbl [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
  logic [3:0] br_tbl    [8] = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd14, 4'd12, 4'd15, 4'd13};
  logic [6:0] op_tbl    [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                                 7'h17, 7'h73, 7'h0F};
  logic [31:0] sys_tbl  [4] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] t;
    t = $signed(v << (32 - w));
    return 32'(t >>> (32 - w));
  endfunction

  // Reference decode written from the ISA field rules.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    int cls;
    bit ill;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i;
    f3 = ins[14:12];
    f7 = ins[31:25];
    imm_i = sext({20'b0, ins[31:20]}, 12);
    cls = 0;
    ill = 1'b0;
    e.pc = pc;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd = ins[11:7];
    e.f3 = f3;
    e.alu = 4'd0;
    e.exc = 4'd0;
    e.imm = 32'd0;
    e.opc = 11'd0;
    e.chk_imm = 1'b1;
    case (ins[6:0])
      7'h33: begin
        cls = 0;
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.alu = arith_tbl[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
        if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd9;
      end
      7'h13: begin
        cls = 1;
        e.alu = arith_tbl[f3];
        if (f3 == 3'd5 && f7[5]) e.alu = 4'd9;
        e.imm = imm_i;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = {27'b0, ins[24:20]};
          ill = (f3 == 3'd1) ? (f7 != 7'h00) : !(f7 == 7'h00 || f7 == 7'h20);
        end
      end
      7'h03: begin
        cls = 2;
        e.imm = imm_i;
        ill = (f3 == 3'd3 || f3 >= 3'd6);
      end
      7'h23: begin
        cls = 3;
        e.rd = 5'd0;
        e.imm = sext({20'b0, ins[31:25], ins[11:7]}, 12);
        ill = (f3 > 3'd2);
      end
      7'h63: begin
        cls = 4;
        e.rd = 5'd0;
        e.imm = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        ill = (f3 == 3'd2 || f3 == 3'd3);
        e.alu = br_tbl[f3];
      end
      7'h6F: begin
        cls = 5;
        e.imm = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      7'h67: begin
        cls = 6;
        e.imm = imm_i;
        ill = (f3 != 3'd0);
      end
      7'h37, 7'h17: begin
        cls = (ins[6:0] == 7'h37) ? 7 : 8;
        e.imm = ins & 32'hFFFF_F000;
      end
      7'h73: begin
        cls = 9;
        e.imm = imm_i;
        if (f3 == 3'd0) begin
          e.rd = 5'd0;
          if (ins == 32'h0000_0073) e.exc[1] = 1'b1;
          else if (ins == 32'h0010_0073) e.exc[2] = 1'b1;
          else if (ins == 32'h3020_0073) e.exc[3] = 1'b1;
          else ill = 1'b1;
        end
      end
      7'h0F: begin
        cls = 10;
        e.rd = 5'd0;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.exc = 4'b0001;
      e.rd = 5'd0;
      e.alu = 4'd0;
      e.chk_imm = 1'b0;
    end else begin
      e.opc = 11'd1 << cls;
    end
    return e;
  endfunction

  // Apply one cycle of inputs at a negedge; queue the result of the next edge.
  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input bit ce,
                       input bit stall, input bit flush);
    item_t it;
    bus.i_pc = pc;
    bus.i_instr = ins;
    bus.i_ce = ce;
    bus.i_stall = stall;
    bus.i_flush = flush;
    #1;
    check("rs1_addr_comb", 32'(bus.o_rs1_addr_comb), 32'(ins[19:15]));
    check("rs2_addr_comb", 32'(bus.o_rs2_addr_comb), 32'(ins[24:20]));
    check("o_stall", 32'(bus.o_stall), 32'(stall));
    check("o_flush", 32'(bus.o_flush), 32'(flush));
    if (!stall) begin
      it.ce = ce && !flush;
      it.upd = ce;
      it.d = model(pc, ins);
      sbq.push_back(it);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int unsigned r;
    ins = $urandom();
    r = $urandom_range(0, 9);
    if (r == 1) begin
      ins = sys_tbl[$urandom_range(0, 3)];
    end else if (r != 0) begin
      ins[6:0] = op_tbl[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return ins;
  endfunction

  // Monitor: an edge without stall consumes one queued item.
  initial begin : monitor
    exp_t  cur;
    bit    cur_ce;
    bit    adv;
    item_t it;
    cur = '{pc: PcReset, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, f3: 3'd0, alu: 4'd0,
            opc: 11'd0, exc: 4'd0, chk_imm: 1'b1};
    cur_ce = 1'b0;
    wait (rstn === 1'b1);
    forever begin
      @(posedge clk);
      adv = !bus.o_stall;
      #2;
      if (adv) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: DUT advanced, got no queued item, required one at %0t",
                   $time);
        end else begin
          it = sbq.pop_front();
          cur_ce = it.ce;
          if (it.upd) cur = it.d;
        end
      end
      check("o_ce", 32'(bus.o_ce), 32'(cur_ce));
      check("o_pc", bus.o_pc, cur.pc);
      check("o_rs1_addr", 32'(bus.o_rs1_addr), 32'(cur.rs1));
      check("o_rs2_addr", 32'(bus.o_rs2_addr), 32'(cur.rs2));
      check("o_rd_addr", 32'(bus.o_rd_addr), 32'(cur.rd));
      check("o_funct3", 32'(bus.o_funct3), 32'(cur.f3));
      check("o_alu_op", 32'(bus.o_alu_op), 32'(cur.alu));
      check("o_opcode", 32'(bus.o_opcode), 32'(cur.opc));
      check("o_exception", 32'(bus.o_exception), 32'(cur.exc));
      if (cur.chk_imm) check("o_imm", bus.o_imm, cur.imm);
    end
  end

  initial begin : stimulus
    logic [31:0] pc;
    bus.i_pc = '0;
    bus.i_instr = '0;
    bus.i_ce = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_o_ce", 32'(bus.o_ce), 32'd0);
    check("rst_o_pc", bus.o_pc, PcReset);
    check("rst_o_opcode", 32'(bus.o_opcode), 32'd0);
    check("rst_o_imm", bus.o_imm, 32'd0);
    check("rst_o_exception", 32'(bus.o_exception), 32'd0);
    check("rst_o_rd_addr", 32'(bus.o_rd_addr), 32'd0);
    check("rst_o_alu_op", 32'(bus.o_alu_op), 32'd0);
    rstn = 1'b1;

    drive(32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0);
    drive(32'h104, 32'h4020_81B3, 1'b1, 1'b0, 1'b0);
    drive(32'h108, 32'hFE20_8CE3, 1'b1, 1'b0, 1'b0);
    drive(32'h10C, 32'h1234_52B7, 1'b1, 1'b0, 1'b0);
    drive(32'h110, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    drive(32'h114, 32'h0000_0073, 1'b1, 1'b0, 1'b0);
    drive(32'h118, 32'h3020_0073, 1'b1, 1'b0, 1'b0);
    drive(32'h11C, 32'h0010_0073, 1'b1, 1'b0, 1'b0);
    drive(32'h120, 32'h4050_D213, 1'b1, 1'b0, 1'b0);
    // Stall three cycles while the input keeps changing.
    drive(32'h200, 32'h0030_0193, 1'b1, 1'b1, 1'b0);
    drive(32'h204, 32'h0041_2223, 1'b1, 1'b1, 1'b0);
    drive(32'h208, 32'h0080_006F, 1'b1, 1'b1, 1'b0);
    drive(32'h20C, 32'h00A0_0113, 1'b1, 1'b0, 1'b0);
    // Flush alone clears o_ce; flush under stall leaves it set.
    drive(32'h300, 32'h0050_0093, 1'b1, 1'b0, 1'b1);
    drive(32'h304, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    drive(32'h308, 32'h0010_0093, 1'b1, 1'b1, 1'b1);
    drive(32'h30C, 32'h0020_0093, 1'b1, 1'b0, 1'b0);
    drive(32'h310, 32'h0030_0093, 1'b0, 1'b0, 1'b0);

    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      drive(pc, rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0));
      pc = pc + 32'd4;
    end
    drive(pc, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    drive(pc, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
